// File: rtl/seq_arb_ctrl.sv
// Sequential grant controller: arbitrates N_CH request lines (round-robin or fixed
// priority), holds one grant for len+1 cycles, and reports completion/abort.
module seq_arb_ctrl #(
    parameter int N_CH  = 7,
    parameter int CNT_W = 4,
    parameter int ID_W  = 3
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [N_CH-1:0]  req,
    input  logic [CNT_W-1:0] len,
    input  logic             mode,
    output logic [N_CH-1:0]  gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ID_W:0] N_CH_W = (ID_W + 1)'(N_CH);

    logic [1:0]       state_q,  state_d;
    logic [N_CH-1:0]  gnt_q,    gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  ptr_q,    ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             abort_q,  abort_d;

    logic [N_CH-1:0]  req_rot;
    logic [ID_W-1:0]  rr_off;
    logic [ID_W:0]    rr_sum;
    logic [ID_W:0]    ptr_inc;
    logic [ID_W-1:0]  win;
    logic             hold_ok;

    function automatic logic [ID_W-1:0] lowest_set(input logic [N_CH-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    // Round-robin search: rotate requests so ptr lands on bit 0, then map the
    // lowest set offset back to an absolute channel index modulo N_CH.
    always_comb begin
        req_rot = N_CH'({req, req} >> ptr_q);
        rr_off  = lowest_set(req_rot);
        rr_sum  = {1'b0, ptr_q} + {1'b0, rr_off};
        if (rr_sum >= N_CH_W) rr_sum = rr_sum - N_CH_W;
        win     = mode ? lowest_set(req) : rr_sum[ID_W-1:0];
        ptr_inc = {1'b0, win} + 1'b1;
        if (ptr_inc == N_CH_W) ptr_inc = '0;
        hold_ok = |(req & gnt_q);
    end

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        abort_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d  = S_GNT;
                    gnt_d    = {{(N_CH-1){1'b0}}, 1'b1} << win;
                    gnt_id_d = win;
                    cnt_d    = len;
                    ptr_d    = ptr_inc[ID_W-1:0];
                end
            end
            S_GNT: begin
                // A dropped request wins over normal expiry on the same cycle.
                if (!hold_ok) begin
                    state_d = S_DONE;
                    gnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                    gnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign abort  = abort_q;

    a_gnt_onehot:  assert property (@(posedge CK) disable iff (RST) $onehot0(gnt));
    a_done_state:  assert property (@(posedge CK) disable iff (RST) done |-> (state_q == S_DONE));
    a_abort_done:  assert property (@(posedge CK) disable iff (RST) abort |-> done);
    a_gnt_busy:    assert property (@(posedge CK) disable iff (RST) (|gnt) |-> busy);

endmodule

// File: tb/tb_seq_arb_ctrl.sv
// Bench for seq_arb_ctrl: a 7-channel and a 16-channel instance, expected grants
// queued per scenario and compared as each grant completes.
module tb_seq_arb_ctrl;

    logic ck = 1'b0;
    logic ck_en = 1'b1;
    logic rst = 1'b0;

    logic [6:0]  req_a = '0;
    logic [3:0]  len_a = '0;
    logic        mode_a = 1'b0;
    logic [6:0]  gnt_a;
    logic [2:0]  gnt_id_a;
    logic        busy_a, done_a, abort_a;

    logic [15:0] req_b = '0;
    logic [3:0]  len_b = '0;
    logic        mode_b = 1'b0;
    logic [15:0] gnt_b;
    logic [3:0]  gnt_id_b;
    logic        busy_b, done_b, abort_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int hold;
        bit abrt;
    } exp_t;

    exp_t sb[$];

    seq_arb_ctrl #(.N_CH(7), .CNT_W(4), .ID_W(3)) dut_a (
        .CK(ck), .RST(rst), .req(req_a), .len(len_a), .mode(mode_a),
        .gnt(gnt_a), .gnt_id(gnt_id_a), .busy(busy_a), .done(done_a), .abort(abort_a)
    );

    seq_arb_ctrl #(.N_CH(16), .CNT_W(4), .ID_W(4)) dut_b (
        .CK(ck), .RST(rst), .req(req_b), .len(len_b), .mode(mode_b),
        .gnt(gnt_b), .gnt_id(gnt_id_b), .busy(busy_b), .done(done_b), .abort(abort_b)
    );

    always begin
        #5;
        if (ck_en) ck = ~ck;
    end

    always @(posedge ck) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] cur_gnt(input bit sel);
        return sel ? gnt_b : {9'b0, gnt_a};
    endfunction

    function automatic int cur_id(input bit sel);
        return sel ? int'(gnt_id_b) : int'(gnt_id_a);
    endfunction

    function automatic logic [2:0] cur_flags(input bit sel);
        return sel ? {busy_b, done_b, abort_b} : {busy_a, done_a, abort_a};
    endfunction

    task automatic check_all_low(input string name);
        checks++;
        if (gnt_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0 || abort_a !== 1'b0 ||
            gnt_b !== '0 || busy_b !== 1'b0 || done_b !== 1'b0 || abort_b !== 1'b0) begin
            errors++;
            $display("FAIL %s: gnt_a=%b busy/done/abort_a=%b%b%b gnt_b=%h busy/done/abort_b=%b%b%b, required all 0",
                     name, gnt_a, busy_a, done_a, abort_a, gnt_b, busy_b, done_b, abort_b);
        end
    endtask

    task automatic apply_reset();
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
    endtask

    // Waits for a grant, pops its expectation, measures hold length and checks
    // the completion strobes on the cycle after the grant drops.
    task automatic collect_grant(input bit sel, input int budget, input int flip_at,
                                 output int start);
        exp_t e;
        int waited = 0;
        int hold = 0;
        logic [15:0] g0;
        int id0;
        start = -1;
        while (cur_gnt(sel) == '0 && waited < budget) begin
            @(negedge ck);
            waited++;
        end
        checks++;
        if (cur_gnt(sel) == '0) begin
            errors++;
            $display("FAIL grant_timeout: no grant on dut %0d within %0d cycles", sel, budget);
            return;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: grant id %0d seen with nothing expected", cur_id(sel));
            return;
        end
        e = sb.pop_front();
        start = cyc;
        g0 = cur_gnt(sel);
        id0 = cur_id(sel);
        while (cur_gnt(sel) == g0 && hold < 40) begin
            if (hold == flip_at) mode_a = ~mode_a;
            checks++;
            if (cur_flags(sel) !== 3'b100) begin
                errors++;
                $display("FAIL busy_during_grant: busy/done/abort=%b, required 100", cur_flags(sel));
            end
            @(negedge ck);
            hold++;
        end
        checks++;
        if (id0 != e.id) begin
            errors++;
            $display("FAIL grant_id: got %0d, required %0d", id0, e.id);
        end
        checks++;
        if (g0 !== (16'd1 << e.id)) begin
            errors++;
            $display("FAIL grant_onehot: got %h, required %h", g0, 16'd1 << e.id);
        end
        checks++;
        if (hold != e.hold) begin
            errors++;
            $display("FAIL hold_len: channel %0d held %0d cycles, required %0d", id0, hold, e.hold);
        end
        checks++;
        if (cur_gnt(sel) !== '0 || cur_flags(sel) !== {1'b1, 1'b1, e.abrt}) begin
            errors++;
            $display("FAIL done_strobe: gnt=%h busy/done/abort=%b, required gnt=0 flags=11%0d",
                     cur_gnt(sel), cur_flags(sel), e.abrt);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1 check_all_low("reset_state");
        checks++;
        if (gnt_id_a !== '0 || gnt_id_b !== '0) begin
            errors++;
            $display("FAIL reset_gnt_id: gnt_id_a=%0d gnt_id_b=%0d, required 0", gnt_id_a, gnt_id_b);
        end
        @(negedge ck);
        rst = 1'b0;
        len_a = 4'd5;
        req_a = 7'b0000001;
        @(negedge ck);
        checks++;
        if (gnt_a !== 7'b0000001 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: gnt=%b busy=%b, required 0000001/1", gnt_a, busy_a);
        end
        // Freeze the clock low mid-grant and reset asynchronously.
        ck_en = 1'b0;
        #12 rst = 1'b1;
        #1 check_all_low("reset_clock_stopped");
        #1 rst = 1'b0;
        #3 ck_en = 1'b1;
        @(negedge ck);
        checks++;
        if (gnt_a !== 7'b0000001 || gnt_id_a !== 3'd0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL grant_after_reset: gnt=%b id=%0d busy=%b done=%b, required 0000001/0/1/0",
                     gnt_a, gnt_id_a, busy_a, done_a);
        end
        req_a = '0;
        repeat (4) @(negedge ck);
    endtask

    task automatic test_hold_length();
        int s;
        apply_reset();
        len_a = 4'd3;
        mode_a = 1'b0;
        req_a = 7'b0000100;
        sb.push_back('{id: 2, hold: 4, abrt: 1'b0});
        collect_grant(1'b0, 10, -1, s);
        @(negedge ck);
        req_a = '0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || gnt_a !== '0) begin
            errors++;
            $display("FAIL idle_after_done: busy=%b done=%b gnt=%b, required 0/0/0", busy_a, done_a, gnt_a);
        end
        repeat (2) @(negedge ck);
    endtask

    task automatic test_round_robin();
        int s;
        int prev = -1;
        int order[6] = '{0, 1, 6, 0, 1, 6};
        apply_reset();
        len_a = 4'd0;
        mode_a = 1'b0;
        req_a = 7'b1000011;
        foreach (order[i]) sb.push_back('{id: order[i], hold: 1, abrt: 1'b0});
        for (int i = 0; i < 6; i++) begin
            collect_grant(1'b0, 10, -1, s);
            if (i > 0) begin
                checks++;
                if (s - prev != 3) begin
                    errors++;
                    $display("FAIL rr_spacing: grant %0d started %0d cycles after previous, required 3", i, s - prev);
                end
            end
            prev = s;
        end
        req_a = '0;
        repeat (3) @(negedge ck);
    endtask

    task automatic test_fixed_priority();
        int s;
        mode_a = 1'b1;
        len_a = 4'd0;
        req_a = 7'b1000011;
        repeat (3) sb.push_back('{id: 0, hold: 1, abrt: 1'b0});
        for (int i = 0; i < 3; i++) collect_grant(1'b0, 10, -1, s);
        len_a = 4'd2;
        sb.push_back('{id: 0, hold: 3, abrt: 1'b0});
        sb.push_back('{id: 1, hold: 3, abrt: 1'b0});
        collect_grant(1'b0, 10, 1, s);
        collect_grant(1'b0, 10, -1, s);
        req_a = '0;
        mode_a = 1'b0;
        repeat (3) @(negedge ck);
    endtask

    task automatic test_abort();
        int waited = 0;
        len_a = 4'd5;
        req_a = 7'b0001000;
        while (gnt_a == '0 && waited < 10) begin
            @(negedge ck);
            waited++;
        end
        @(negedge ck);
        checks++;
        if (gnt_a !== 7'b0001000 || gnt_id_a !== 3'd3) begin
            errors++;
            $display("FAIL abort_grant: gnt=%b id=%0d, required 0001000/3", gnt_a, gnt_id_a);
        end
        req_a = '0;
        @(negedge ck);
        checks++;
        if (gnt_a !== '0 || busy_a !== 1'b1 || done_a !== 1'b1 || abort_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_strobe: gnt=%b busy=%b done=%b abort=%b, required 0/1/1/1",
                     gnt_a, busy_a, done_a, abort_a);
        end
        @(negedge ck);
        checks++;
        if (gnt_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0 || abort_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: gnt=%b busy=%b done=%b abort=%b, required all 0",
                     gnt_a, busy_a, done_a, abort_a);
        end
    endtask

    task automatic test_wide();
        int s;
        int waited = 0;
        apply_reset();
        len_b = 4'd0;
        mode_b = 1'b0;
        req_b = 16'h8000;
        sb.push_back('{id: 15, hold: 1, abrt: 1'b0});
        sb.push_back('{id: 0, hold: 1, abrt: 1'b0});
        while (gnt_b == '0 && waited < 10) begin
            @(negedge ck);
            waited++;
        end
        req_b = 16'hFFFF;
        collect_grant(1'b1, 10, -1, s);
        collect_grant(1'b1, 10, -1, s);
        req_b = '0;
        repeat (3) @(negedge ck);
    endtask

    initial begin
        test_reset();
        test_hold_length();
        test_round_robin();
        test_fixed_priority();
        test_abort();
        test_wide();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expected grants never seen", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
